frame_write_sequencer: RTL and testbench

- Parametrised successor to the per-state frame write-enable decode.
- Owns the instruction state machine (IDLE/DECODE/SETUP/EXECUTE/WRITEBACK) and drives write enables for NUM_FRAMES instruction frames, rotating round-robin.
- Adds an instruction accept handshake, multi-cycle execute, writeback stall, flush, and per-frame result-valid tracking.
- Sits between instruction fetch and the frame register bank.

---
 rtl/frame_seq_pkg.sv | 32 +++
 rtl/frame_field_decode.sv | 30 +++
 rtl/frame_write_sequencer.sv | 132 +++++++++++++
 tb/tb_frame_write_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared constants for the frame write sequencer.
//   - State encodings driven on the 'state' output.
//   - Field indices inside one frame's 12-bit write-enable slice.
//   - field_bit(): one-hot mask helper for building field masks.
package frame_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_SETUP     = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;

  localparam int unsigned FIELD_COUNT = 12;

  localparam int unsigned FLD_AOPERAND    = 0;
  localparam int unsigned FLD_ALOC        = 1;
  localparam int unsigned FLD_BOPERAND    = 2;
  localparam int unsigned FLD_BLOC        = 3;
  localparam int unsigned FLD_IMM         = 4;
  localparam int unsigned FLD_IMMSLCT     = 5;
  localparam int unsigned FLD_UNSIGNED    = 6;
  localparam int unsigned FLD_SUBENABLE   = 7;
  localparam int unsigned FLD_RESULTSLCT  = 8;
  localparam int unsigned FLD_WRITESLCT   = 9;
  localparam int unsigned FLD_WRITEENABLE = 10;
  localparam int unsigned FLD_RESULT      = 11;

  function automatic logic [FIELD_COUNT-1:0] field_bit(input int unsigned idx);
    return FIELD_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/frame_field_decode.sv
// Per-frame field write-enable decode.
//   state      : registered sequencer state
//   frame_sel  : this frame is the one being filled (and no flush)
//   field_mask : 12-bit write-enable mask for this frame
module frame_field_decode
  import frame_seq_pkg::*;
(
  input  logic [2:0]             state,
  input  logic                   frame_sel,
  output logic [FIELD_COUNT-1:0] field_mask
);

  always_comb begin
    field_mask = '0;
    if (frame_sel) begin
      case (state)
        ST_DECODE: field_mask = field_bit(FLD_ALOC)       | field_bit(FLD_BLOC)       |
                                field_bit(FLD_IMM)        | field_bit(FLD_IMMSLCT)    |
                                field_bit(FLD_UNSIGNED)   | field_bit(FLD_SUBENABLE)  |
                                field_bit(FLD_RESULTSLCT) | field_bit(FLD_WRITESLCT)  |
                                field_bit(FLD_WRITEENABLE);
        ST_SETUP:  field_mask = field_bit(FLD_AOPERAND) | field_bit(FLD_BOPERAND);
        ST_EXECUTE,
        ST_WRITEBACK: field_mask = field_bit(FLD_RESULT);
        default:   field_mask = '0;
      endcase
    end
  end

endmodule

// File: rtl/frame_write_sequencer.sv
// Instruction state machine driving write enables for NUM_FRAMES frames,
// filled round-robin.
//   clk, reset_n   : clock, asynchronous active-low reset
//   instr_valid/ready, exec_cycles : instruction accept handshake + execute length
//   wb_ready       : register-file write port granted
//   flush          : synchronous abort to IDLE (highest priority)
//   state          : encoded current state
//   frame_ptr      : frame currently being filled
//   field_we       : write enables, bit = frame*12 + field
//   frame_valid    : per-frame completed-result flags
module frame_write_sequencer
  import frame_seq_pkg::*;
#(
  parameter  int unsigned NUM_FRAMES = 2,
  parameter  int unsigned EXEC_CNT_W = 4,
  localparam int unsigned PTR_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              instr_valid,
  output logic                              instr_ready,
  input  logic [EXEC_CNT_W-1:0]             exec_cycles,
  input  logic                              wb_ready,
  input  logic                              flush,
  output logic [2:0]                        state,
  output logic [PTR_W-1:0]                  frame_ptr,
  output logic [FIELD_COUNT*NUM_FRAMES-1:0] field_we,
  output logic [NUM_FRAMES-1:0]             frame_valid
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_FRAMES - 1);

  logic [2:0]            state_q, state_d;
  logic [PTR_W-1:0]      frame_ptr_q, frame_ptr_d;
  logic [EXEC_CNT_W-1:0] cnt_q, cnt_d;
  logic [EXEC_CNT_W-1:0] len_q, len_d;
  logic [NUM_FRAMES-1:0] frame_valid_q, frame_valid_d;
  logic                  transfer;
  logic [EXEC_CNT_W-1:0] exec_len;

  // A zero length is run as a single execute cycle.
  assign exec_len = (exec_cycles == '0) ? EXEC_CNT_W'(1) : exec_cycles;

  always_comb begin
    instr_ready = 1'b0;
    if (reset_n && !flush) begin
      case (state_q)
        ST_IDLE:      instr_ready = 1'b1;
        ST_WRITEBACK: instr_ready = wb_ready;
        default:      instr_ready = 1'b0;
      endcase
    end
  end

  assign transfer = instr_valid && instr_ready;

  // Flush freezes pointer, counter and valid flags; a flush in DECODE therefore
  // leaves the frame's valid flag untouched since no field was written.
  always_comb begin
    state_d       = state_q;
    frame_ptr_d   = frame_ptr_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    frame_valid_d = frame_valid_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (transfer) begin
            len_d   = exec_len;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          frame_valid_d[frame_ptr_q] = 1'b0;
          state_d                    = ST_SETUP;
        end
        ST_SETUP: begin
          cnt_d   = len_q;
          state_d = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= EXEC_CNT_W'(1)) state_d = ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (wb_ready) begin
            frame_valid_d[frame_ptr_q] = 1'b1;
            frame_ptr_d = (frame_ptr_q == LAST_PTR) ? '0 : frame_ptr_q + 1'b1;
            if (transfer) begin
              len_d   = exec_len;
              state_d = ST_DECODE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      frame_ptr_q   <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      frame_valid_q <= '0;
    end else begin
      state_q       <= state_d;
      frame_ptr_q   <= frame_ptr_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_frame
    frame_field_decode u_decode (
      .state      (state_q),
      .frame_sel  (!flush && (frame_ptr_q == PTR_W'(f))),
      .field_mask (field_we[f*FIELD_COUNT +: FIELD_COUNT])
    );
  end

  assign state       = state_q;
  assign frame_ptr   = frame_ptr_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
module tb_frame_write_sequencer;

  localparam int unsigned NF = 2;
  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DEC  = 3'd1;
  localparam logic [2:0] S_SET  = 3'd2;
  localparam logic [2:0] S_EXE  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [CW-1:0] exec_cycles = '0;
  logic          wb_ready = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    state;
  logic          frame_ptr;
  logic [23:0]   field_we;
  logic [1:0]    frame_valid;

  always #5 clk = ~clk;

  frame_write_sequencer #(.NUM_FRAMES(NF), .EXEC_CNT_W(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .exec_cycles (exec_cycles),
    .wb_ready    (wb_ready),
    .flush       (flush),
    .state       (state),
    .frame_ptr   (frame_ptr),
    .field_we    (field_we),
    .frame_valid (frame_valid)
  );

  typedef struct {
    int          id;
    logic [2:0]  st;
    logic        ptr;
    logic [1:0]  fv;
    logic        rdy;
    logic [23:0] we;
  } exp_t;

  exp_t sb[$];
  int   check_cnt = 0;
  int   err_cnt   = 0;
  int   cyc_id    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected enables from the field table: DECODE 0x7FA, SETUP 0x005, EXECUTE/WRITEBACK 0x800.
  function automatic logic [23:0] we_for(input logic [2:0] st, input logic ptr, input logic fl);
    logic [11:0] m;
    case (st)
      S_DEC:       m = 12'h7FA;
      S_SET:       m = 12'h005;
      S_EXE, S_WB: m = 12'h800;
      default:     m = 12'h000;
    endcase
    if (fl) m = 12'h000;
    return ptr ? {m, 12'h000} : {12'h000, m};
  endfunction

  // Drive one cycle of inputs and push what the DUT must show during that cycle.
  task automatic cyc(input logic rst, input logic iv, input logic [CW-1:0] ex,
                     input logic wb, input logic fl, input logic [2:0] est,
                     input logic eptr, input logic [1:0] efv, input logic erdy);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n     = rst;
    instr_valid = iv;
    exec_cycles = ex;
    wb_ready    = wb;
    flush       = fl;
    e.id  = cyc_id;
    e.st  = est;
    e.ptr = eptr;
    e.fv  = efv;
    e.rdy = erdy;
    e.we  = we_for(est, eptr, fl);
    cyc_id++;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check($sformatf("c%0d state", e.id),       32'(state),       32'(e.st));
      check($sformatf("c%0d frame_ptr", e.id),   32'(frame_ptr),   32'(e.ptr));
      check($sformatf("c%0d frame_valid", e.id), 32'(frame_valid), 32'(e.fv));
      check($sformatf("c%0d instr_ready", e.id), 32'(instr_ready), 32'(e.rdy));
      check($sformatf("c%0d field_we", e.id),    32'(field_we),    32'(e.we));
    end
  end

  initial begin
    // reset held, instr_valid must be ignored
    cyc(0, 1, 3, 1, 0, S_IDLE, 0, 2'b00, 0);
    cyc(0, 1, 3, 1, 0, S_IDLE, 0, 2'b00, 0);
    // release; exec=3, wb_ready=1
    cyc(1, 1, 3, 1, 0, S_IDLE, 0, 2'b00, 1);
    cyc(1, 0, 0, 1, 0, S_DEC,  0, 2'b00, 0);
    cyc(1, 0, 0, 1, 0, S_SET,  0, 2'b00, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, S_EXE, 0, 2'b00, 0);
    cyc(1, 0, 0, 1, 0, S_WB,   0, 2'b00, 1);
    // exec=0 behaves as one execute cycle, frame 1
    cyc(1, 1, 0, 1, 0, S_IDLE, 1, 2'b01, 1);
    cyc(1, 0, 0, 1, 0, S_DEC,  1, 2'b01, 0);
    cyc(1, 0, 0, 1, 0, S_SET,  1, 2'b01, 0);
    cyc(1, 0, 0, 1, 0, S_EXE,  1, 2'b01, 0);
    cyc(1, 0, 0, 1, 0, S_WB,   1, 2'b01, 1);
    // writeback stall for 4 cycles, pointer wrapped to 0
    cyc(1, 1, 1, 0, 0, S_IDLE, 0, 2'b11, 1);
    cyc(1, 0, 0, 0, 0, S_DEC,  0, 2'b11, 0);
    cyc(1, 0, 0, 0, 0, S_SET,  0, 2'b10, 0);
    cyc(1, 0, 0, 0, 0, S_EXE,  0, 2'b10, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, S_WB, 0, 2'b10, 0);
    cyc(1, 0, 0, 1, 0, S_WB,   0, 2'b10, 1);
    // back-to-back, exec=1, instr_valid held high
    cyc(1, 1, 1, 1, 0, S_IDLE, 1, 2'b11, 1);
    cyc(1, 1, 1, 1, 0, S_DEC,  1, 2'b11, 0);
    cyc(1, 1, 1, 1, 0, S_SET,  1, 2'b01, 0);
    cyc(1, 1, 1, 1, 0, S_EXE,  1, 2'b01, 0);
    cyc(1, 1, 1, 1, 0, S_WB,   1, 2'b01, 1);
    cyc(1, 1, 1, 1, 0, S_DEC,  0, 2'b11, 0);
    cyc(1, 1, 1, 1, 0, S_SET,  0, 2'b10, 0);
    cyc(1, 1, 1, 1, 0, S_EXE,  0, 2'b10, 0);
    cyc(1, 1, 1, 1, 0, S_WB,   0, 2'b10, 1);
    cyc(1, 1, 1, 1, 0, S_DEC,  1, 2'b11, 0);
    cyc(1, 0, 0, 1, 0, S_SET,  1, 2'b01, 0);
    cyc(1, 0, 0, 1, 0, S_EXE,  1, 2'b01, 0);
    cyc(1, 0, 0, 1, 0, S_WB,   1, 2'b01, 1);
    // flush in execute cycle 2 of 4, with a competing instr_valid
    cyc(1, 1, 4, 0, 0, S_IDLE, 0, 2'b11, 1);
    cyc(1, 0, 0, 0, 0, S_DEC,  0, 2'b11, 0);
    cyc(1, 0, 0, 0, 0, S_SET,  0, 2'b10, 0);
    cyc(1, 0, 0, 0, 0, S_EXE,  0, 2'b10, 0);
    cyc(1, 1, 4, 0, 1, S_EXE,  0, 2'b10, 0);
    cyc(1, 0, 0, 0, 0, S_IDLE, 0, 2'b10, 1);
    // flush together with wb_ready in writeback
    cyc(1, 1, 1, 1, 0, S_IDLE, 0, 2'b10, 1);
    cyc(1, 0, 0, 1, 0, S_DEC,  0, 2'b10, 0);
    cyc(1, 0, 0, 1, 0, S_SET,  0, 2'b10, 0);
    cyc(1, 0, 0, 1, 0, S_EXE,  0, 2'b10, 0);
    cyc(1, 1, 1, 1, 1, S_WB,   0, 2'b10, 0);
    // asynchronous reset mid-execute, then recovery
    cyc(1, 1, 4, 0, 0, S_IDLE, 0, 2'b10, 1);
    cyc(1, 0, 0, 0, 0, S_DEC,  0, 2'b10, 0);
    cyc(1, 0, 0, 0, 0, S_SET,  0, 2'b10, 0);
    cyc(1, 0, 0, 0, 0, S_EXE,  0, 2'b10, 0);
    cyc(0, 1, 4, 0, 0, S_IDLE, 0, 2'b00, 0);
    cyc(0, 1, 4, 0, 0, S_IDLE, 0, 2'b00, 0);
    cyc(1, 1, 1, 1, 0, S_IDLE, 0, 2'b00, 1);
    cyc(1, 0, 0, 1, 0, S_DEC,  0, 2'b00, 0);
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
